// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU sequencer: register offsets, control-byte bit
// positions, FSM state encoding and the control-byte builder.
package tpu_pkg;

    localparam logic [7:0] OFF_CTRL = 8'h00;
    localparam logic [7:0] OFF_B0   = 8'h01;
    localparam logic [7:0] OFF_B1   = 8'h02;
    localparam logic [7:0] OFF_TX   = 8'h03;
    localparam logic [7:0] OFF_RX   = 8'h04;

    localparam int CTRL_RSTTPU  = 0;
    localparam int CTRL_TXEN    = 1;
    localparam int CTRL_RXEN    = 2;
    localparam int CTRL_INTMSK  = 3;
    localparam int CTRL_INTFLAG = 4;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_W_RST  = 4'd1,
        ST_W_B0   = 4'd2,
        ST_W_B1   = 4'd3,
        ST_W_TX   = 4'd4,
        ST_W_RX   = 4'd5,
        ST_W_RUN  = 4'd6,
        ST_RUN    = 4'd7,
        ST_W_ACK  = 4'd8,
        ST_W_STOP = 4'd9
    } tpu_seq_state_e;

    // Intflag is always written as 0, which is what clears a pending interrupt.
    function automatic logic [7:0] ctrl_byte(input logic rsttpu, input logic [2:0] mode);
        logic [7:0] b;
        b               = 8'h00;
        b[CTRL_RSTTPU]  = rsttpu;
        b[CTRL_TXEN]    = mode[0];
        b[CTRL_RXEN]    = mode[1];
        b[CTRL_INTMSK]  = mode[2];
        b[CTRL_INTFLAG] = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/tpu_edge_det.sv
// Rising-edge detector: registered copy of the input, compared against the
// live level. The copy is updated every cycle regardless of FSM state.
module tpu_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic prev_r;

    // Track the previous level of din.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= din;
        end
    end

    assign rise = din & ~prev_r;

endmodule

// File: rtl/tpu_sequencer.sv
// TPU configuration / interrupt-service sequencer. Programs the timer register
// file, acknowledges interrupts while running and shuts the timer down on request.
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h20,
    parameter int          CNT_W     = 16
) (
    input  logic             sys_clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [15:0]      period,
    input  logic [7:0]       tx_slot_cfg,
    input  logic [7:0]       rx_slot_cfg,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] max_irq,
    input  logic             tpu_int,
    output logic             valid,
    output logic [7:0]       addr,
    output logic [7:0]       wr_data,
    output logic             busy,
    output logic             running,
    output logic             irq_ack,
    output logic [CNT_W-1:0] irq_count,
    output logic             done
);

    tpu_seq_state_e   state_r;
    tpu_seq_state_e   state_next_s;

    logic [15:0]      period_r;
    logic [7:0]       tx_slot_r;
    logic [7:0]       rx_slot_r;
    logic [2:0]       mode_r;
    logic [CNT_W-1:0] max_irq_r;
    logic [CNT_W-1:0] irq_count_r;

    logic             valid_r;
    logic [7:0]       addr_r;
    logic [7:0]       wr_data_r;
    logic             busy_r;
    logic             running_r;
    logic             irq_ack_r;
    logic             done_r;

    logic             irq_rise_s;
    logic             limit_hit_s;
    logic [7:0]       run_ctrl_s;
    logic             wr_valid_s;
    logic [7:0]       wr_addr_s;
    logic [7:0]       wr_byte_s;

    tpu_edge_det u_edge_det (
        .clk   (sys_clock),
        .reset (reset),
        .din   (tpu_int),
        .rise  (irq_rise_s)
    );

    assign run_ctrl_s  = ctrl_byte(1'b0, mode_r);
    // irq_count_r already holds the incremented value while in W_ACK.
    assign limit_hit_s = (max_irq_r != {CNT_W{1'b0}}) && (irq_count_r == max_irq_r);

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_W_RST;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_W_RST:  state_next_s = ST_W_B0;
            ST_W_B0:   state_next_s = ST_W_B1;
            ST_W_B1:   state_next_s = ST_W_TX;
            ST_W_TX:   state_next_s = ST_W_RX;
            ST_W_RX:   state_next_s = ST_W_RUN;
            ST_W_RUN:  state_next_s = ST_RUN;
            ST_RUN: begin
                if (stop) begin
                    state_next_s = ST_W_STOP;
                end else if (irq_rise_s) begin
                    state_next_s = ST_W_ACK;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_W_ACK: begin
                if (limit_hit_s) begin
                    state_next_s = ST_W_STOP;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_W_STOP: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Register write decoded from the upcoming state so the strobe is registered.
    always_comb begin
        wr_valid_s = 1'b0;
        wr_addr_s  = 8'h00;
        wr_byte_s  = 8'h00;
        case (state_next_s)
            ST_W_RST: begin
                wr_valid_s = 1'b1;
                wr_addr_s  = BASE_ADDR + OFF_CTRL;
                wr_byte_s  = ctrl_byte(1'b1, 3'b000);
            end
            ST_W_B0: begin
                wr_valid_s = 1'b1;
                wr_addr_s  = BASE_ADDR + OFF_B0;
                wr_byte_s  = period_r[7:0];
            end
            ST_W_B1: begin
                wr_valid_s = 1'b1;
                wr_addr_s  = BASE_ADDR + OFF_B1;
                wr_byte_s  = period_r[15:8];
            end
            ST_W_TX: begin
                wr_valid_s = 1'b1;
                wr_addr_s  = BASE_ADDR + OFF_TX;
                wr_byte_s  = tx_slot_r;
            end
            ST_W_RX: begin
                wr_valid_s = 1'b1;
                wr_addr_s  = BASE_ADDR + OFF_RX;
                wr_byte_s  = rx_slot_r;
            end
            ST_W_RUN, ST_W_ACK: begin
                wr_valid_s = 1'b1;
                wr_addr_s  = BASE_ADDR + OFF_CTRL;
                wr_byte_s  = run_ctrl_s;
            end
            ST_W_STOP: begin
                wr_valid_s = 1'b1;
                wr_addr_s  = BASE_ADDR + OFF_CTRL;
                wr_byte_s  = ctrl_byte(1'b1, 3'b000);
            end
            default: begin
                wr_valid_s = 1'b0;
                wr_addr_s  = 8'h00;
                wr_byte_s  = 8'h00;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            valid_r   <= 1'b0;
            addr_r    <= 8'h00;
            wr_data_r <= 8'h00;
            busy_r    <= 1'b0;
            running_r <= 1'b0;
            irq_ack_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            valid_r   <= wr_valid_s;
            addr_r    <= wr_addr_s;
            wr_data_r <= wr_byte_s;
            busy_r    <= (state_next_s != ST_IDLE);
            running_r <= (state_next_s == ST_RUN);
            irq_ack_r <= (state_next_s == ST_W_ACK);
            done_r    <= (state_r == ST_W_STOP);
        end
    end

    // Configuration snapshot and interrupt counter; both restart on an accepted start.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            period_r    <= 16'h0000;
            tx_slot_r   <= 8'h00;
            rx_slot_r   <= 8'h00;
            mode_r      <= 3'b000;
            max_irq_r   <= {CNT_W{1'b0}};
            irq_count_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_IDLE) && start) begin
            period_r    <= period;
            tx_slot_r   <= tx_slot_cfg;
            rx_slot_r   <= rx_slot_cfg;
            mode_r      <= mode;
            max_irq_r   <= max_irq;
            irq_count_r <= {CNT_W{1'b0}};
        end else if (state_next_s == ST_W_ACK) begin
            irq_count_r <= irq_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            irq_count_r <= irq_count_r;
        end
    end

    assign valid     = valid_r;
    assign addr      = addr_r;
    assign wr_data   = wr_data_r;
    assign busy      = busy_r;
    assign running   = running_r;
    assign irq_ack   = irq_ack_r;
    assign irq_count = irq_count_r;
    assign done      = done_r;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed bench for tpu_sequencer: a per-cycle vector table for the main
// program / service / auto-stop flow plus hand-written corner sequences.
module tb_tpu_sequencer;

    logic        sys_clock;
    logic        reset;
    logic        start;
    logic        stop;
    logic [15:0] period;
    logic [7:0]  tx_slot_cfg;
    logic [7:0]  rx_slot_cfg;
    logic [2:0]  mode;
    logic [15:0] max_irq;
    logic        tpu_int;
    logic        valid;
    logic [7:0]  addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        running;
    logic        irq_ack;
    logic [15:0] irq_count;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        start;
        logic        stop;
        logic        tint;
        logic        e_valid;
        logic [7:0]  e_addr;
        logic [7:0]  e_data;
        logic        e_busy;
        logic        e_run;
        logic        e_ack;
        logic [15:0] e_cnt;
        logic        e_done;
    } vec_t;

    vec_t tbl [15];

    tpu_sequencer #(.BASE_ADDR(8'h20), .CNT_W(16)) dut (
        .sys_clock   (sys_clock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .period      (period),
        .tx_slot_cfg (tx_slot_cfg),
        .rx_slot_cfg (rx_slot_cfg),
        .mode        (mode),
        .max_irq     (max_irq),
        .tpu_int     (tpu_int),
        .valid       (valid),
        .addr        (addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .running     (running),
        .irq_ack     (irq_ack),
        .irq_count   (irq_count),
        .done        (done)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    task automatic step();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_valid, input logic [7:0] e_addr,
                           input logic [7:0] e_data, input logic e_busy, input logic e_run,
                           input logic e_ack, input logic [15:0] e_cnt, input logic e_done);
        chk({tag, ".valid"},   {31'd0, valid},   {31'd0, e_valid});
        chk({tag, ".addr"},    {24'd0, addr},    {24'd0, e_addr});
        chk({tag, ".wr_data"}, {24'd0, wr_data}, {24'd0, e_data});
        chk({tag, ".busy"},    {31'd0, busy},    {31'd0, e_busy});
        chk({tag, ".running"}, {31'd0, running}, {31'd0, e_run});
        chk({tag, ".irq_ack"}, {31'd0, irq_ack}, {31'd0, e_ack});
        chk({tag, ".count"},   {16'd0, irq_count}, {16'd0, e_cnt});
        chk({tag, ".done"},    {31'd0, done},    {31'd0, e_done});
    endtask

    initial begin
        //          start stop tint  valid addr   data   busy run  ack  cnt    done
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 8'h01, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h21, 8'h05, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 8'h06, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h23, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h24, 8'h04, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 8'h0E, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 8'h0E, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 8'h0E, 1'b1, 1'b0, 1'b1, 16'd2, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 8'h01, 1'b1, 1'b0, 1'b0, 16'd2, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0};

        reset       = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        period      = 16'h0605;
        tx_slot_cfg = 8'h00;
        rx_slot_cfg = 8'h04;
        mode        = 3'b111;
        max_irq     = 16'd2;
        tpu_int     = 1'b0;
        step();
        step();
        chk_out("reset", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        reset = 1'b0;
        step();

        // Program, service (3-cycle interrupt level), auto-stop after two.
        for (int i = 0; i < 15; i++) begin
            start   = tbl[i].start;
            stop    = tbl[i].stop;
            tpu_int = tbl[i].tint;
            step();
            chk_out($sformatf("tbl%0d", i), tbl[i].e_valid, tbl[i].e_addr, tbl[i].e_data,
                    tbl[i].e_busy, tbl[i].e_run, tbl[i].e_ack, tbl[i].e_cnt, tbl[i].e_done);
        end

        // Collision: stop and an interrupt rise in the same RUN cycle.
        max_irq = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("col.start_clears_count", {16'd0, irq_count}, 32'd0);
        repeat (6) step();
        chk("col.running", {31'd0, running}, 32'd1);
        stop    = 1'b1;
        tpu_int = 1'b1;
        step();
        stop    = 1'b0;
        tpu_int = 1'b0;
        chk_out("col.wstop", 1'b1, 8'h20, 8'h01, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
        step();
        chk_out("col.done", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1);

        // Stop in IDLE does nothing.
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_out("idle_stop", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);

        // Start during W_B1 ignored; config changes ignored; early tpu_int level not counted.
        start = 1'b1;
        step();
        start   = 1'b0;
        tpu_int = 1'b1;
        step();
        chk("ign.b0", {24'd0, addr, wr_data}, {16'd0, 8'h21, 8'h05});
        step();
        chk("ign.b1", {24'd0, addr, wr_data}, {16'd0, 8'h22, 8'h06});
        start  = 1'b1;
        period = 16'hAAAA;
        step();
        start = 1'b0;
        chk("ign.tx", {23'd0, valid, addr, wr_data}, {23'd0, 1'b1, 8'h23, 8'h00});
        step();
        chk("ign.rx", {23'd0, valid, addr, wr_data}, {23'd0, 1'b1, 8'h24, 8'h04});
        step();
        chk("ign.run_wr", {23'd0, valid, addr, wr_data}, {23'd0, 1'b1, 8'h20, 8'h0E});
        step();
        chk_out("ign.run", 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
        tpu_int = 1'b0;
        step();
        chk_out("ign.run2", 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("ign.wstop", {23'd0, valid, addr, wr_data}, {23'd0, 1'b1, 8'h20, 8'h01});
        step();
        chk("ign.done", {31'd0, done}, 32'd1);
        period = 16'h0605;

        // Reset asserted while in W_TX.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("rst.in_tx", {23'd0, valid, addr, wr_data}, {23'd0, 1'b1, 8'h23, 8'h00});
        reset = 1'b1;
        step();
        chk_out("rst.mid", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
        reset = 1'b0;
        step();
        chk_out("rst.after", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
